mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu (legal range 1..31).
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal range 1..31).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  issue a mult/multu/div/divu operation.
REQ-006 sel  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 111 none.
REQ-007 mf_sel  input  2  read select: 00 HI, 01 LO, 10 none.
REQ-008 a  input  32  rs operand.
REQ-009 b  input  32  rt operand.
REQ-010 req  input  1  exception/interrupt flush; suppresses any new operation in the same cycle.
REQ-011 busy  output  1  operation in progress.
REQ-012 md_pending  output  1  busy OR accepted start this cycle; used for stalling.
REQ-013 rd  output  32  HI/LO read data.
REQ-014 hi  output  32  current HI register.
REQ-015 lo  output  32  current LO register.

Function
REQ-016 FSM states IDLE and BUSY; 5-bit down-counter cnt.
REQ-017 Accepted start: start=1, sel in 000..011, req=0, state IDLE; otherwise start has no effect.
REQ-018 On accepted start at edge ending cycle t: latch a, b, sel; cnt <= N-1 (N = MULT_CYCLES or DIV_CYCLES); state -> BUSY.
REQ-019 BUSY: cnt decrements each edge; at edge with cnt=0, HI/LO written with result and state -> IDLE.
REQ-020 busy high exactly cycles t+1..t+N; new HI/LO visible from cycle t+N+1, when busy is 0.
REQ-021 start while BUSY is ignored; latched operands and count are unaffected.
REQ-022 mthi/mtlo (sel 100/101, req=0, IDLE): HI or LO <= a at next edge; busy stays 0; start ignored for these sel values.
REQ-023 mthi/mtlo while BUSY is ignored.
REQ-024 req=1 while BUSY does not cancel the running operation.
REQ-025 mult: {HI,LO} = signed 64-bit a*b; multu: unsigned 64-bit product.
REQ-026 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient and remainder.
REQ-027 Results are computed from latched operands, independent of a/b after acceptance.
REQ-028 rd combinational: mf_sel 00 -> hi, 01 -> lo, else 0.
REQ-029 md_pending = busy | accepted start (combinational).

Reset
REQ-030 reset=1 forces state IDLE, cnt 0, HI 0, LO 0, latched operands 0, busy 0, asynchronously.
REQ-031 Reset mid-operation discards the running operation; HI/LO stay 0 after release.
REQ-032 First edge after reset release accepts a valid start normally.

Configuration
REQ-033 Macro MDU_DIV0_HOLD_EN: defined -> div/divu with b=0 completes after DIV_CYCLES with HI and LO unchanged.
REQ-034 Macro MDU_DIV0_HOLD_EN undefined -> div/divu with b=0 writes HI = a, LO = 32'hFFFF_FFFF.
REQ-035 Multiply behaviour and all timing are identical with or without the macro.

Verification
REQ-036 mult a=32'hFFFF_FFFE (-2), b=3 -> busy 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
REQ-037 multu a=32'hFFFF_FFFF, b=2 -> HI=1, LO=32'hFFFF_FFFE; div a=-7, b=2 -> busy 10 cycles, LO=-3, HI=-1.
REQ-038 start with req=1 (divu a=9, b=2) -> busy stays 0, HI/LO unchanged; mthi a=5 with req=1 -> HI unchanged.
REQ-039 mult issued, then start divu and mtlo at cycles 2 and 3 of busy -> both ignored; only mult result lands at cycle t+6.
REQ-040 div a=42, b=0 -> macro defined: HI/LO unchanged; undefined: HI=42, LO=32'hFFFF_FFFF.
REQ-041 reset asserted during div cycle 4 -> busy 0 and HI/LO 0 immediately, no later write; mtlo a=7 then mf_sel=01 -> rd=7.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Handshake/bus bundle for the multiply/divide controller. The master drives the
// operation request and operands; the slave returns status, HI/LO and read data.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  sel;
  logic [1:0]  mf_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic        md_pending;
  logic [31:0] rd;
  logic [31:0] hi;
  logic [31:0] lo;

  // An operation is taken when start is high with a mult/div sel, req is low and the
  // unit is idle; there is no ready signal, so md_pending is used to stall the issuer.
  modport master (
    output start, sel, mf_sel, a, b, req,
    input  busy, md_pending, rd, hi, lo
  );

  modport slave (
    input  start, sel, mf_sel, a, b, req,
    output busy, md_pending, rd, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MIPS-style HI/LO multiply/divide controller with mthi/mtlo and mfhi/mflo.
// Optional macro MDU_DIV0_HOLD_EN: divide by zero leaves HI/LO unchanged.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus,
  output logic       dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [4:0] MULT_LD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LD  = 5'(DIV_CYCLES - 1);

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;
  logic        busy_q;

  logic        accept;
  logic        move_ok;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign accept  = bus.start && !bus.req && (state_q == IDLE) && !bus.sel[2];
  assign move_ok = !bus.req && (state_q == IDLE);

  // One 64-bit multiplier serves both flavours: sign-extend only for signed mult.
  assign ext_a = {{32{a_q[31] & ~op_q[0]}}, a_q};
  assign ext_b = {{32{b_q[31] & ~op_q[0]}}, b_q};
  assign prod  = ext_a * ext_b;

  // Signed divide via magnitudes so the quotient truncates toward zero and the
  // remainder follows the dividend's sign; b_div keeps the divider away from zero.
  assign a_neg = ~op_q[0] & a_q[31];
  assign b_neg = ~op_q[0] & b_q[31];
  assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
  assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.sel[1:0];
            cnt_q   <= bus.sel[1] ? DIV_LD : MULT_LD;
            state_q <= BUSY;
            busy_q  <= 1'b1;
          end else if (move_ok && bus.sel == 3'b100) begin
            hi_q <= bus.a;
          end else if (move_ok && bus.sel == 3'b101) begin
            lo_q <= bus.a;
          end
        end
        BUSY: begin
          if (cnt_q == 5'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!op_q[1]) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end else if (b_q == 32'd0) begin
`ifdef MDU_DIV0_HOLD_EN
              hi_q <= hi_q;
              lo_q <= lo_q;
`else
              hi_q <= a_q;
              lo_q <= 32'hFFFF_FFFF;
`endif
            end else begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.md_pending = busy_q | accept;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign dbg_state_o    = (state_q == BUSY);

  always_comb begin
    bus.rd = 32'd0;
    case (bus.mf_sel)
      2'b00:   bus.rd = hi_q;
      2'b01:   bus.rd = lo_q;
      default: bus.rd = 32'd0;
    endcase
  end

endmodule
